// File: rtl/wb_retire_stage_pkg.sv
// Shared field layout and trace-entry types for the writeback/retire stage.
package wb_retire_stage_pkg;

    localparam int LANE_W  = 71;
    localparam int HILO_W  = 66;
    localparam int TRACE_W = 70;

    localparam int VALID_BIT = 70;
    localparam int PC_HI     = 69;
    localparam int PC_LO     = 38;
    localparam int WE_BIT    = 37;
    localparam int WADDR_HI  = 36;
    localparam int WADDR_LO  = 32;
    localparam int WDATA_HI  = 31;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } trace_t;

    typedef struct packed {
        logic        lo_we;
        logic        hi_we;
        logic [63:0] data;
    } hilo_t;

    // Trace entries keep the unsuppressed write enable so the golden trace sees every write.
    function automatic trace_t to_trace(input logic [LANE_W-1:0] lane);
        return trace_t'({lane[PC_HI:PC_LO], lane[WE_BIT], lane[WADDR_HI:WADDR_LO], lane[WDATA_HI:0]});
    endfunction

endpackage

// File: rtl/wb_retire_stage_trace_fifo.sv
// Retire-trace FIFO: multi-lane compacting push, single show-ahead pop per cycle.
module wb_trace_fifo
    import wb_retire_stage_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0]           push_valid,
    input  logic [LANES*TRACE_W-1:0]   push_data,
    output trace_t                     head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    trace_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;
    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] offset [LANES];
    logic [LANES-1:0] accept;
    logic             drop;

    assign pop        = (count != '0);
    assign free_slots = CNT_W'(DEPTH) - count;

    // Free space excludes the concurrent pop, so a full-ish FIFO drops the youngest lanes first.
    always_comb begin
        accepted = '0;
        accept   = '0;
        drop     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            offset[i] = accepted;
            if (push_valid[i]) begin
                if (accepted < free_slots) begin
                    accept[i] = 1'b1;
                    accepted  = accepted + CNT_W'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (accept[i]) begin
                mem[wr_ptr + PTR_W'(offset[i])] <= push_data[i*TRACE_W +: TRACE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(accepted);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + accepted - CNT_W'(pop);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign head = pop ? mem[rd_ptr] : '0;

endmodule

// File: rtl/wb_retire_stage.sv
// Multi-lane MEM->WB stage register with write-conflict resolution and retire-trace serialisation.
module wb_retire_stage
    import wb_retire_stage_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int DBG_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      stall_up,
    input  logic                      stall_wb,
    input  logic [LANES*LANE_W-1:0]   in_bus,
    input  logic [HILO_W-1:0]         in_hilo,
    output logic [LANES-1:0]          rf_we,
    output logic [LANES*5-1:0]        rf_waddr,
    output logic [LANES*32-1:0]       rf_wdata,
    output logic                      hi_we,
    output logic                      lo_we,
    output logic [63:0]               hilo_wdata,
    output logic                      wb_busy,
    output logic                      dbg_overflow,
    output logic [31:0]               debug_wb_pc,
    output logic [3:0]                debug_wb_rf_wen,
    output logic [4:0]                debug_wb_rf_wnum,
    output logic [31:0]               debug_wb_rf_wdata
);

    localparam int CNT_W = $clog2(DBG_DEPTH) + 1;

    logic [LANES*LANE_W-1:0]  stage_q;
    hilo_t                    hilo_q;
    logic                     load;
    logic [LANES-1:0]         lane_we;
    logic [LANES-1:0]         push_valid;
    logic [LANES*TRACE_W-1:0] push_data;
    trace_t                   head;
    logic [CNT_W-1:0]         count;

    assign load = !flush && !stall_up && !stall_wb;

    // Flush and bubbles clear the register, which also gates the HI/LO enables.
    always_ff @(posedge clk) begin
        if (rst || flush || (stall_up && !stall_wb)) begin
            stage_q <= '0;
            hilo_q  <= '0;
        end else if (!stall_wb) begin
            stage_q <= in_bus;
            hilo_q  <= hilo_t'(in_hilo);
        end
    end

    always_comb begin
        lane_we  = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_we[i]        = stage_q[i*LANE_W + VALID_BIT] && stage_q[i*LANE_W + WE_BIT];
            rf_waddr[i*5 +: 5] = stage_q[i*LANE_W + WADDR_LO +: 5];
            rf_wdata[i*32 +: 32] = stage_q[i*LANE_W +: 32];
        end
    end

    // A younger lane writing the same nonzero register overrides every older one.
    always_comb begin
        rf_we = lane_we;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (lane_we[i] && lane_we[j] && (rf_waddr[i*5 +: 5] == rf_waddr[j*5 +: 5])
                    && (rf_waddr[i*5 +: 5] != 5'd0)) begin
                    rf_we[i] = 1'b0;
                end
            end
        end
    end

    assign hi_we      = hilo_q.hi_we;
    assign lo_we      = hilo_q.lo_we;
    assign hilo_wdata = hilo_q.data;

    always_comb begin
        push_valid = '0;
        push_data  = '0;
        for (int i = 0; i < LANES; i++) begin
            push_valid[i]                    = load && in_bus[i*LANE_W + VALID_BIT];
            push_data[i*TRACE_W +: TRACE_W]  = to_trace(in_bus[i*LANE_W +: LANE_W]);
        end
    end

    wb_trace_fifo #(
        .LANES (LANES),
        .DEPTH (DBG_DEPTH)
    ) u_trace_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_data  (push_data),
        .head       (head),
        .count      (count),
        .overflow   (dbg_overflow)
    );

    assign wb_busy           = (CNT_W'(DBG_DEPTH) - count) < CNT_W'(LANES);
    assign debug_wb_pc       = head.pc;
    assign debug_wb_rf_wen   = {4{head.we}};
    assign debug_wb_rf_wnum  = head.waddr;
    assign debug_wb_rf_wdata = head.wdata;

endmodule

// File: tb/tb_wb_retire_stage.sv
// Directed self-checking bench for wb_retire_stage with LANES=2, DBG_DEPTH=8.
module tb_wb_retire_stage;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam logic [70:0] NONE = '0;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               stall_up;
    logic               stall_wb;
    logic [LANES*71-1:0] in_bus;
    logic [65:0]        in_hilo;
    logic [LANES-1:0]   rf_we;
    logic [LANES*5-1:0] rf_waddr;
    logic [LANES*32-1:0] rf_wdata;
    logic               hi_we;
    logic               lo_we;
    logic [63:0]        hilo_wdata;
    logic               wb_busy;
    logic               dbg_overflow;
    logic [31:0]        debug_wb_pc;
    logic [3:0]         debug_wb_rf_wen;
    logic [4:0]         debug_wb_rf_wnum;
    logic [31:0]        debug_wb_rf_wdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_retire_stage #(
        .LANES     (LANES),
        .DBG_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .stall_up          (stall_up),
        .stall_wb          (stall_wb),
        .in_bus            (in_bus),
        .in_hilo           (in_hilo),
        .rf_we             (rf_we),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .hi_we             (hi_we),
        .lo_we             (lo_we),
        .hilo_wdata        (hilo_wdata),
        .wb_busy           (wb_busy),
        .dbg_overflow      (dbg_overflow),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    function automatic logic [70:0] mk_lane(input logic v, input logic [31:0] pc, input logic we,
                                            input logic [4:0] wa, input logic [31:0] wd);
        return {v, pc, we, wa, wd};
    endfunction

    task automatic apply_stimulus(input logic [70:0] l0, input logic [70:0] l1, input logic [65:0] hilo);
        in_bus  = {l1, l0};
        in_hilo = hilo;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        stall_up = 1'b0;
        stall_wb = 1'b0;
        in_bus   = '0;
        in_hilo  = '0;
        apply_stimulus(NONE, NONE, '0);
        apply_stimulus(NONE, NONE, '0);
        rst = 1'b0;
        check_output("reset_rf_we", 64'(rf_we), 64'h0);
        check_output("reset_dbg_pc", 64'(debug_wb_pc), 64'h0);
        check_output("reset_overflow", 64'(dbg_overflow), 64'h0);
        check_output("reset_busy", 64'(wb_busy), 64'h0);
        check_output("reset_hilo_we", 64'({hi_we, lo_we}), 64'h0);

        apply_stimulus(mk_lane(1'b1, 32'hBFC00000, 1'b1, 5'd3, 32'h1234), NONE, '0);
        check_output("single_rf_we", 64'(rf_we), 64'h1);
        check_output("single_waddr0", 64'(rf_waddr[4:0]), 64'd3);
        check_output("single_wdata0", 64'(rf_wdata[31:0]), 64'h1234);
        check_output("single_dbg_pc", 64'(debug_wb_pc), 64'hBFC00000);
        check_output("single_dbg_wen", 64'(debug_wb_rf_wen), 64'hF);
        check_output("single_dbg_wnum", 64'(debug_wb_rf_wnum), 64'd3);
        check_output("single_dbg_wdata", 64'(debug_wb_rf_wdata), 64'h1234);
        apply_stimulus(NONE, NONE, '0);
        check_output("single_rf_we_after", 64'(rf_we), 64'h0);
        check_output("single_dbg_pc_after", 64'(debug_wb_pc), 64'h0);

        apply_stimulus(mk_lane(1'b1, 32'h100, 1'b1, 5'd1, 32'h11), mk_lane(1'b1, 32'h104, 1'b1, 5'd2, 32'h22), '0);
        check_output("dual_rf_we", 64'(rf_we), 64'h3);
        check_output("dual_waddr", 64'(rf_waddr), 64'({5'd2, 5'd1}));
        check_output("dual_dbg_pc0", 64'(debug_wb_pc), 64'h100);
        apply_stimulus(NONE, NONE, '0);
        check_output("dual_dbg_pc1", 64'(debug_wb_pc), 64'h104);
        check_output("dual_dbg_wnum1", 64'(debug_wb_rf_wnum), 64'd2);
        apply_stimulus(NONE, NONE, '0);
        check_output("dual_dbg_empty", 64'(debug_wb_pc), 64'h0);

        apply_stimulus(mk_lane(1'b1, 32'h200, 1'b1, 5'd5, 32'hAA), mk_lane(1'b1, 32'h204, 1'b1, 5'd5, 32'hBB), '0);
        check_output("conflict_rf_we", 64'(rf_we), 64'h2);
        check_output("conflict_wdata1", 64'(rf_wdata[63:32]), 64'hBB);
        check_output("conflict_dbg_wen0", 64'(debug_wb_rf_wen), 64'hF);
        apply_stimulus(NONE, NONE, '0);
        check_output("conflict_dbg_pc1", 64'(debug_wb_pc), 64'h204);
        check_output("conflict_dbg_wen1", 64'(debug_wb_rf_wen), 64'hF);
        apply_stimulus(NONE, NONE, '0);

        apply_stimulus(mk_lane(1'b1, 32'h300, 1'b1, 5'd0, 32'h1), mk_lane(1'b1, 32'h304, 1'b1, 5'd0, 32'h2), '0);
        check_output("zero_addr_rf_we", 64'(rf_we), 64'h3);
        apply_stimulus(NONE, NONE, '0);
        check_output("zero_addr_dbg_pc1", 64'(debug_wb_pc), 64'h304);
        apply_stimulus(NONE, NONE, '0);

        stall_up = 1'b1;
        apply_stimulus(mk_lane(1'b1, 32'h400, 1'b1, 5'd7, 32'h77), NONE, '0);
        check_output("bubble_rf_we", 64'(rf_we), 64'h0);
        check_output("bubble_dbg_pc", 64'(debug_wb_pc), 64'h0);
        stall_up = 1'b0;

        apply_stimulus(mk_lane(1'b1, 32'h500, 1'b1, 5'd8, 32'h55), NONE, '0);
        check_output("prestall_dbg_pc", 64'(debug_wb_pc), 64'h500);
        stall_wb = 1'b1;
        for (int c = 0; c < 3; c++) begin
            apply_stimulus(mk_lane(1'b1, 32'h600, 1'b1, 5'd9, 32'h66), NONE, '0);
            check_output("stall_hold_rf_we", 64'(rf_we), 64'h1);
            check_output("stall_hold_waddr0", 64'(rf_waddr[4:0]), 64'd8);
            check_output("stall_hold_wdata0", 64'(rf_wdata[31:0]), 64'h55);
        end
        check_output("stall_no_push", 64'(debug_wb_pc), 64'h0);
        stall_wb = 1'b0;
        apply_stimulus(NONE, NONE, '0);
        check_output("stall_release_rf_we", 64'(rf_we), 64'h0);

        flush = 1'b1;
        apply_stimulus(mk_lane(1'b1, 32'h700, 1'b1, 5'd4, 32'h44), NONE, '0);
        check_output("flush_rf_we", 64'(rf_we), 64'h0);
        check_output("flush_dbg_pc", 64'(debug_wb_pc), 64'h0);
        flush = 1'b0;

        apply_stimulus(NONE, NONE, {1'b1, 1'b1, 64'h00000001_FFFFFFFE});
        check_output("hilo_we", 64'({hi_we, lo_we}), 64'h3);
        check_output("hilo_wdata", hilo_wdata, 64'h00000001_FFFFFFFE);
        stall_up = 1'b1;
        apply_stimulus(NONE, NONE, {1'b1, 1'b1, 64'h00000001_FFFFFFFE});
        check_output("hilo_bubble_we", 64'({hi_we, lo_we}), 64'h0);
        stall_up = 1'b0;

        for (int k = 1; k <= 7; k++) begin
            apply_stimulus(mk_lane(1'b1, 32'h1000 + 32'(k * 16), 1'b1, 5'(k), 32'(k)),
                           mk_lane(1'b1, 32'h1004 + 32'(k * 16), 1'b1, 5'(k + 8), 32'(k)), '0);
            if (k == 5) check_output("bp_busy_count6", 64'(wb_busy), 64'h0);
            if (k == 6) begin
                check_output("bp_busy_count7", 64'(wb_busy), 64'h1);
                check_output("bp_no_overflow_yet", 64'(dbg_overflow), 64'h0);
            end
        end
        check_output("bp_overflow_set", 64'(dbg_overflow), 64'h1);
        check_output("bp_busy_held", 64'(wb_busy), 64'h1);
        check_output("bp_head_pc", 64'(debug_wb_pc), 64'h1040);
        for (int c = 0; c < 3; c++) apply_stimulus(NONE, NONE, '0);
        check_output("bp_drain_pc", 64'(debug_wb_pc), 64'h1054);
        check_output("bp_overflow_sticky", 64'(dbg_overflow), 64'h1);

        rst = 1'b1;
        apply_stimulus(NONE, NONE, '0);
        rst = 1'b0;
        check_output("rst_drain_dbg_pc", 64'(debug_wb_pc), 64'h0);
        check_output("rst_drain_overflow", 64'(dbg_overflow), 64'h0);
        check_output("rst_drain_busy", 64'(wb_busy), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
